// File: rtl/ram_arb2.sv
// Two-requester arbiter in front of a simple dual-port RAM (one write port, one read port).
// Optional write-to-read byte forwarding is enabled by defining RAM_ARB2_FWD_EN.
module ram_arb2 #(
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned BYTES_IN_WORD = 4,
  parameter int unsigned WORD_COUNT    = 256,
  localparam int unsigned ADDR_WIDTH   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1,
  localparam int unsigned WORD_WIDTH   = BYTE_WIDTH * BYTES_IN_WORD
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  // Write requesters
  input  logic [1:0]                          wr_valid_i,
  output logic [1:0]                          wr_ready_o,
  input  logic [1:0][BYTES_IN_WORD-1:0]       wr_be_i,
  input  logic [1:0][ADDR_WIDTH-1:0]          wr_addr_i,
  input  logic [1:0][WORD_WIDTH-1:0]          wr_data_i,
  // Read requesters
  input  logic [1:0]                          rd_valid_i,
  output logic [1:0]                          rd_ready_o,
  input  logic [1:0][ADDR_WIDTH-1:0]          rd_addr_i,
  output logic [1:0]                          rd_rvalid_o,
  output logic [WORD_WIDTH-1:0]               rd_rdata_o,
  // RAM side
  output logic                                ram_we_o,
  output logic [BYTES_IN_WORD-1:0]            ram_be_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_a_o,
  output logic [WORD_WIDTH-1:0]               ram_data_a_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_b_o,
  input  logic [WORD_WIDTH-1:0]               ram_data_b_i
);

  // Round-robin pick: a lone requester wins, a tie goes to the priority holder.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic prio);
    logic [1:0] gnt;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  logic                  r_wr_prio;
  logic                  r_rd_prio;
  logic [1:0]            r_rvalid;
  logic [1:0]            w_wr_gnt;
  logic [1:0]            w_rd_gnt;
  logic                  w_wr_sel;
  logic                  w_rd_sel;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [WORD_WIDTH-1:0] w_rdata;

  always_comb begin
    w_wr_gnt = rst_i ? 2'b00 : rr_grant(wr_valid_i, r_wr_prio);
    w_rd_gnt = rst_i ? 2'b00 : rr_grant(rd_valid_i, r_rd_prio);
    w_wr_sel = w_wr_gnt[1];
    w_rd_sel = w_rd_gnt[1];
    w_wr_acc = |w_wr_gnt;
    w_rd_acc = |w_rd_gnt;
  end

  always_comb begin
    wr_ready_o   = w_wr_gnt;
    rd_ready_o   = w_rd_gnt;
    ram_we_o     = w_wr_acc;
    ram_be_o     = wr_be_i[w_wr_sel];
    ram_addr_a_o = wr_addr_i[w_wr_sel];
    ram_data_a_o = wr_data_i[w_wr_sel];
    ram_addr_b_o = rd_addr_i[w_rd_sel];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_prio <= 1'b0;
      r_rd_prio <= 1'b0;
      r_rvalid  <= 2'b00;
    end else begin
      if (w_wr_acc) r_wr_prio <= ~w_wr_sel;
      if (w_rd_acc) r_rd_prio <= ~w_rd_sel;
      r_rvalid <= w_rd_gnt;
    end
  end

`ifdef RAM_ARB2_FWD_EN
  logic [BYTES_IN_WORD-1:0] r_fwd_be;
  logic [WORD_WIDTH-1:0]    r_fwd_data;
  logic                     w_fwd_hit;

  assign w_fwd_hit = w_wr_acc && w_rd_acc && (ram_addr_a_o == ram_addr_b_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_be   <= w_fwd_hit ? ram_be_o : '0;
      r_fwd_data <= ram_data_a_o;
    end
  end

  // The RAM returns pre-write data; overlay the bytes written in the same cycle.
  always_comb begin
    w_rdata = ram_data_b_i;
    for (int i = 0; i < int'(BYTES_IN_WORD); i++) begin
      if (r_fwd_be[i]) w_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = r_fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
`else
  assign w_rdata = ram_data_b_i;
`endif

  // Gating by rst_i drops a response still in flight when reset rises.
  assign rd_rvalid_o = rst_i ? 2'b00 : r_rvalid;
  assign rd_rdata_o  = rst_i ? '0 : w_rdata;

endmodule

// File: doc/ram_arb2.md
RAM_ARB2 -- requirements
Module: ram_arb2

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8: bits per byte lane.
REQ-002 SHALL have parameter BYTES_IN_WORD, default 4: byte lanes per word.
REQ-003 SHALL have parameter WORD_COUNT, default 256: RAM depth.
REQ-004 SHALL derive ADDR_WIDTH = clog2(WORD_COUNT) and WORD_WIDTH = BYTE_WIDTH*BYTES_IN_WORD as localparams.
REQ-005 SHALL use one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  reset.
REQ-006 wr_valid_i  in  2  per-requester write request valid.
REQ-007 wr_ready_o  out  2  per-requester write grant.
REQ-008 wr_be_i / wr_addr_i / wr_data_i  in  2x BYTES_IN_WORD / 2x ADDR_WIDTH / 2x WORD_WIDTH  per-requester write byte enables, address, data.
REQ-009 rd_valid_i  in  2; rd_ready_o  out  2; rd_addr_i  in  2x ADDR_WIDTH  per-requester read request.
REQ-010 rd_rvalid_o  out  2  one-hot read response valid; rd_rdata_o  out  WORD_WIDTH  shared read response data.
REQ-011 ram_we_o  out  1; ram_be_o  out  BYTES_IN_WORD; ram_addr_a_o  out  ADDR_WIDTH; ram_data_a_o  out  WORD_WIDTH  RAM write port.
REQ-012 ram_addr_b_o  out  ADDR_WIDTH  RAM read address; ram_data_b_i  in  WORD_WIDTH  RAM read data, 1-cycle registered latency.

Function
REQ-013 Write and read arbitration SHALL be independent; one write and one read MAY be accepted in the same cycle.
REQ-014 Each arbiter SHALL be 2-way round-robin with a 1-bit priority register; only one requester valid -> it is granted; both valid -> priority holder granted.
REQ-015 After an accepted transfer by requester k, that arbiter's priority SHALL move to requester 1-k; no accept -> priority unchanged.
REQ-016 ready SHALL be combinational from valid and priority, at most one bit set per arbiter, never asserted to a requester whose valid is low.
REQ-017 Accept (valid & ready) on write SHALL drive ram_we_o=1 and forward the granted be/addr/data to the RAM write port in the same cycle.
REQ-018 ram_we_o SHALL be 0 when no write accepted; ram_be_o, ram_addr_a_o, ram_data_a_o are don't-care then.
REQ-019 ram_addr_b_o SHALL carry the granted read address in the accept cycle.
REQ-020 A read accepted at cycle t SHALL produce rd_rvalid_o[k]=1 for exactly one cycle at t+1 with rd_rdata_o = RAM data; no response backpressure.
REQ-021 A requester holding valid while not granted SHALL be granted within 2 cycles (starvation bound).
REQ-022 Same-address read and write accepted in the same cycle SHALL return pre-write data (read-first), unless REQ-027 applies.
REQ-023 Requester signals SHALL be assumed stable only in the accept cycle; no internal buffering of requests.

Reset
REQ-024 While rst_i=1: wr_ready_o=0, rd_ready_o=0, ram_we_o=0, rd_rvalid_o=0, rd_rdata_o=0; both priority registers -> requester 0.
REQ-025 A read accepted in the cycle before rst_i rises SHALL NOT produce rd_rvalid_o; in-flight response is discarded.
REQ-026 First cycle after rst_i falls SHALL arbitrate normally with requester 0 priority.

Configuration
REQ-027 Macro RAM_ARB2_FWD_EN defined: arbiter registers same-cycle write be/data when write and read addresses match; at t+1 enabled bytes of rd_rdata_o SHALL take the written data, other bytes RAM data.
REQ-028 Macro RAM_ARB2_FWD_EN undefined: no forwarding logic; REQ-022 read-first behaviour holds.

Verification
REQ-029 Both wr_valid_i=11 held 4 cycles after reset -> grants 01,10,01,10; ram_we_o=1 each cycle.
REQ-030 rd_valid_i=10, rd_addr_i[1]=0x05, RAM[5]=0xDEADBEEF -> rd_ready_o=10 same cycle; rd_rvalid_o=10, rd_rdata_o=0xDEADBEEF next cycle.
REQ-031 Write req0 addr 0x10 data 0x11223344 be 1111 plus read req1 addr 0x20 same cycle -> both accepted; RAM[0x10] updated; response from 0x20 at t+1.
REQ-032 RAM[7]=0xAAAAAAAA; write addr 7 data 0x12345678 be 0011 with read addr 7 same cycle -> rdata 0xAAAAAAAA without macro, 0xAAAA5678 with RAM_ARB2_FWD_EN.
REQ-033 Read accepted at t, rst_i=1 at t+1 -> rd_rvalid_o=00 at t+1; after release, rd_valid_i=11 -> requester 0 granted first.
REQ-034 Random valids on both ports 10k cycles -> ready one-hot-or-zero, no requester waits more than 2 cycles, all read data matches scoreboard.
